sum_accumulator: RTL
====================

Name: sum_accumulator

Overview:
Downstream consumer of the registered 8-bit adder sum. It accumulates a host-specified burst of adder results into a wider accumulator with sticky overflow, then presents the total on a valid/ready output. It sits between the fast adder and the top-level output mux, and follows the same enable gating as the adder.

Parameters:
DATA_W, 8, width of the incoming adder sum
ACC_W, 16, accumulator width; must be greater than DATA_W
CNT_W, 4, burst-length counter width; maximum burst is 2^CNT_W-1 samples

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
enable  input  1  global enable; when low, all state and outputs hold
start  input  1  begin a burst; sampled only in IDLE
burst_len  input  CNT_W  number of samples to accumulate; latched on start
in_valid  input  1  in_sum carries a new adder result this cycle
in_sum  input  DATA_W  registered adder sum
out_ready  input  1  consumer accepts the result
out_valid  output  1  result available
out_acc  output  ACC_W  accumulated total
out_ovf  output  1  sticky overflow flag for the burst
out_count  output  CNT_W  number of samples actually accumulated
busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset (async, reset_n=0): state=IDLE; acc=0; ovf=0; count=0; len=0; out_valid=0; busy=0. out_acc, out_ovf and out_count read 0. A reset mid-burst discards the burst immediately.
- enable=0: no state, counter, accumulator or output register changes. start, in_valid and out_ready are ignored that cycle.
- States are IDLE, ACCUM and DONE.
- IDLE:
  - On start=1: latch len=burst_len; clear acc, ovf and count.
  - If burst_len=0, go to DONE (result 0, ovf 0, count 0). Otherwise go to ACCUM.
  - in_valid is ignored.
- ACCUM:
  - Each cycle with in_valid=1: acc <= (acc + zero-extended in_sum) mod 2^ACC_W; ovf <= ovf | carry-out of bit ACC_W-1; count <= count+1.
  - When the accepted sample makes count+1 == len, go to DONE on the same edge.
  - start is ignored. in_valid=0 cycles are bubbles with no change.
- DONE:
  - out_valid=1. out_acc, out_ovf and out_count are stable and equal the registered values.
  - On out_valid & out_ready: go to IDLE and drop out_valid next cycle.
  - in_valid and start are ignored. out_ready high while out_valid=0 has no effect.
- Latency: out_valid rises on the clock edge that accepts the last sample, so it is visible the cycle after that sample is presented.
- Back-to-back bursts: start is honoured no earlier than the first IDLE cycle after the handshake, giving a minimum 1-cycle gap.
- busy = (state != IDLE).
- Wrap-around: without the optional feature, acc wraps modulo 2^ACC_W and ovf stays set once set.

Optional Feature:
SUM_ACC_SATURATE_EN
- Defined: on carry-out, acc clamps to 2^ACC_W-1 and stays there for the rest of the burst; ovf is set as before.
- Undefined: modulo wrap as described above.
- Both builds must pass the same tests except the overflow scenario, whose expected out_acc differs.

Decomposition:
- Package sum_acc_pkg:
  - state enum {IDLE, ACCUM, DONE}
  - default width constants DATA_W, ACC_W, CNT_W
  - localparam ACC_MAX
- One natural sub-module, acc_add_stage (combinational):
  - inputs: acc, in_sum
  - outputs: next_acc and carry
  - contains the saturation mux under the macro
- FSM, counter and output registers stay in sum_accumulator.

Test Plan:
- Reset mid-burst: start with len=3, accept one sample 0x10, assert reset_n=0 -> all outputs 0, state IDLE immediately (asynchronous, no clock edge needed).
- Basic burst: len=4, samples 0x01, 0x02, 0x03, 0x04 with in_valid gaps between them -> out_valid=1 the cycle after the 4th sample; out_acc=0x000A, out_count=4, out_ovf=0.
- Zero length: start with burst_len=0 -> DONE next cycle; out_acc=0, out_count=0, out_valid=1.
- Backpressure and enable: hold out_ready=0 for 5 cycles, drop enable for 2 cycles -> outputs stable throughout; handshake at out_ready=1 returns to IDLE and out_valid falls next cycle.
- Overflow with ACC_W=9 override: len=3, samples 0xFF, 0xFF, 0xFF ->
  - without macro: out_acc=0x0FD (765 mod 512), out_ovf=1
  - with SUM_ACC_SATURATE_EN: out_acc=0x1FF, out_ovf=1
- Ignored inputs: start asserted during ACCUM and DONE, in_valid during IDLE and DONE -> no change to acc, count or len.

Source files
------------

// File: rtl/sum_acc_pkg.sv
// sum_acc_pkg: shared types and default widths for the sum accumulator slice.
//   state_t : FSM encoding (IDLE, ACCUM, DONE)
//   DATA_W  : default width of the incoming adder sum
//   ACC_W   : default accumulator width (must exceed DATA_W)
//   CNT_W   : default burst-length counter width
//   ACC_MAX : all-ones value of a default-width accumulator
package sum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int CNT_W  = 4;

    localparam logic [ACC_W-1:0] ACC_MAX = '1;

endpackage

// File: rtl/sum_accumulator_if.sv
// sum_accumulator_if: burst control, sample input and result handshake of
// the sum accumulator.
//   master : drives start/burst_len/in_valid/in_sum/out_ready, observes results
//   slave  : the accumulator itself
//   start, burst_len     : burst request and its sample count
//   in_valid, in_sum     : adder result stream
//   out_valid, out_ready : result handshake
//   out_acc, out_ovf, out_count : burst total, sticky overflow, samples taken
//   busy                 : accumulator is in ACCUM or DONE
interface sum_accumulator_if #(
    parameter int DATA_W = sum_acc_pkg::DATA_W,
    parameter int ACC_W  = sum_acc_pkg::ACC_W,
    parameter int CNT_W  = sum_acc_pkg::CNT_W
);
    logic              start;
    logic [CNT_W-1:0]  burst_len;
    logic              in_valid;
    logic [DATA_W-1:0] in_sum;
    logic              out_ready;
    logic              out_valid;
    logic [ACC_W-1:0]  out_acc;
    logic              out_ovf;
    logic [CNT_W-1:0]  out_count;
    logic              busy;

    modport master (
        output start, burst_len, in_valid, in_sum, out_ready,
        input  out_valid, out_acc, out_ovf, out_count, busy
    );

    modport slave (
        input  start, burst_len, in_valid, in_sum, out_ready,
        output out_valid, out_acc, out_ovf, out_count, busy
    );
endinterface

// File: rtl/acc_add_stage.sv
// acc_add_stage: combinational accumulate step.
//   acc      : current accumulator value
//   in_sum   : incoming adder result (zero-extended)
//   next_acc : updated accumulator (wraps, or clamps with SUM_ACC_SATURATE_EN)
//   carry    : carry-out of bit ACC_W-1
// Macro SUM_ACC_SATURATE_EN: clamp to all-ones on carry instead of wrapping.
module acc_add_stage #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] in_sum,
    output logic [ACC_W-1:0]  next_acc,
    output logic              carry
);
    logic [ACC_W:0] sum_ext;

    always_comb begin
        sum_ext = {1'b0, acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_sum};
        carry   = sum_ext[ACC_W];
`ifdef SUM_ACC_SATURATE_EN
        // Once clamped, any further add carries again, so the value sticks.
        next_acc = carry ? '1 : sum_ext[ACC_W-1:0];
`else
        next_acc = sum_ext[ACC_W-1:0];
`endif
    end
endmodule

// File: rtl/sum_accumulator.sv
// sum_accumulator: accumulates a host-specified burst of adder results into a
// wider accumulator with sticky overflow and offers the total on valid/ready.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   enable  : global enable; when low all state holds and inputs are ignored
//   bus     : sum_accumulator_if slave (burst control, samples, result)
// Macro SUM_ACC_SATURATE_EN (in acc_add_stage): saturating accumulate.
module sum_accumulator #(
    parameter int DATA_W = sum_acc_pkg::DATA_W,
    parameter int ACC_W  = sum_acc_pkg::ACC_W,
    parameter int CNT_W  = sum_acc_pkg::CNT_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    sum_accumulator_if.slave   bus
);
    import sum_acc_pkg::*;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] len;
    logic             out_valid;
    logic             busy;

    logic [ACC_W-1:0] next_acc;
    logic             carry;
    logic [CNT_W-1:0] count_inc;

    acc_add_stage #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc      (acc),
        .in_sum   (bus.in_sum),
        .next_acc (next_acc),
        .carry    (carry)
    );

    assign count_inc = count + CNT_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            count     <= '0;
            len       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        len   <= bus.burst_len;
                        acc   <= '0;
                        ovf   <= 1'b0;
                        count <= '0;
                        busy  <= 1'b1;
                        // Zero-length burst completes immediately with an empty result.
                        if (bus.burst_len == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc   <= next_acc;
                        ovf   <= ovf | carry;
                        count <= count_inc;
                        if (count_inc == len) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_acc   = acc;
    assign bus.out_ovf   = ovf;
    assign bus.out_count = count;
    assign bus.busy      = busy;
endmodule
